// File: rtl/mul_seq_fpga_if.sv
// -----------------------------------------------------------------------------
// mul_seq_fpga_if
// Board-side signal bundle for the sequential multiplier demo.
//
//   s       operand-pair select (board switches)
//   start   request a multiply; only taken while the block is idle
//   button  display half select: 0 = low half, 1 = high half of the product
//   out     selected half of the held result
//   busy    multiply in progress
//   done    one-cycle pulse when the result register is updated
//
// master : board / stimulus side (drives s, start, button)
// slave  : multiplier side (drives out, busy, done)
// -----------------------------------------------------------------------------
interface mul_seq_fpga_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 4
);
    logic [SEL_W-1:0] s;
    logic             start;
    logic             button;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output s,
        output start,
        output button,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  s,
        input  start,
        input  button,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/mul_seq_fpga.sv
// -----------------------------------------------------------------------------
// mul_seq_fpga
// Sequential shift-add multiplier for the board demo. The select lines pick an
// operand pair from a generated table; a start strobe latches the pair and runs
// WIDTH shift-add steps. The 2*WIDTH-bit product is held in a result register
// and one half of it is shown on 'out', chosen by the button.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mul_seq_fpga_if.slave (s, start, button in; out, busy, done out)
//
// Parameters:
//   WIDTH  operand width; product is 2*WIDTH, display is WIDTH
//   SEL_W  select width; 2^(SEL_W-1) table entries are valid, the rest give 0*0
// -----------------------------------------------------------------------------
module mul_seq_fpga #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mul_seq_fpga_if.slave       bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               table_hit;

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   prod;
    logic [2*WIDTH:0]   prod_nxt;
    logic [WIDTH:0]     upper_sum;
    logic [CW-1:0]      cnt;
    logic               last_step;
    logic [2*WIDTH-1:0] result;

    // ------------------------------------------------------------------
    // Operand table: entry s gives (2s+1, 2s+2) mod 2^WIDTH while the top
    // select bit is clear, otherwise both operands are zero.
    // ------------------------------------------------------------------
    always_comb begin
        table_hit = ~bus.s[SEL_W-1];
        op_a      = '0;
        op_b      = '0;
        if (table_hit) begin
            op_a = WIDTH'({bus.s, 1'b1});
            op_b = WIDTH'({1'b0, bus.s, 1'b1} + (SEL_W + 2)'(1));
        end
    end

    // ------------------------------------------------------------------
    // One shift-add step. The top bit of prod is always zero between steps,
    // so the WIDTH+1-bit sum of the upper half and the multiplicand keeps the
    // carry without overflow.
    // ------------------------------------------------------------------
    always_comb begin
        upper_sum = prod[2*WIDTH:WIDTH];
        if (prod[0]) begin
            upper_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
        prod_nxt = {1'b0, upper_sum, prod[WIDTH-1:1]};
    end

    assign last_step = (cnt == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand latch, working product, step counter, result hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= op_a;
                        prod  <= {{(WIDTH + 1){1'b0}}, op_b};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + CW'(1);
                    // The edge finishing step WIDTH loads the shifted value
                    // directly, so done and the new result appear together.
                    if (last_step) begin
                        result <= prod_nxt[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Display half select, combinational so the button acts immediately.
    assign bus.out = bus.button ? result[2*WIDTH-1:WIDTH] : result[WIDTH-1:0];

endmodule

// File: tb/tb_mul_seq_fpga.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_fpga
// Bench for mul_seq_fpga at WIDTH=4 and WIDTH=8. Expected products come from
// plain arithmetic on the operand table rule; timing expectations come from the
// documented start/busy/done latency.
// -----------------------------------------------------------------------------
module tb_mul_seq_fpga;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    mul_seq_fpga_if #(.WIDTH(4), .SEL_W(4)) b4 ();
    mul_seq_fpga_if #(.WIDTH(8), .SEL_W(4)) b8 ();

    mul_seq_fpga #(.WIDTH(4), .SEL_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4.slave)
    );

    mul_seq_fpga #(.WIDTH(8), .SEL_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: product of the table pair selected by sv.
    function automatic int unsigned ref_prod(input int unsigned sv, input int unsigned w,
                                             input int unsigned selw);
        int unsigned a;
        int unsigned b;
        if (sv < (32'd1 << (selw - 1))) begin
            a = (2 * sv + 1) % (32'd1 << w);
            b = (2 * sv + 2) % (32'd1 << w);
            return a * b;
        end
        return 0;
    endfunction

    // Launch one multiply on the 4-bit instance and record what is seen.
    task automatic observe4(input int unsigned sv, input int smid,
                            output int bcnt, output int dat, output int dcnt,
                            output int ovl, output logic [7:0] prod);
        bcnt = 0; dat = -1; dcnt = 0; ovl = 0; prod = '0;
        @(negedge clk);
        b4.s = 4'(sv);
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        if (smid >= 0) b4.s = 4'(smid);
        for (int c = 1; c <= 7; c++) begin
            if (b4.busy) bcnt++;
            if (b4.busy && b4.done) ovl++;
            if (b4.done) begin
                dcnt++;
                dat = c;
                b4.button = 1'b0;
                #1 prod[3:0] = b4.out;
                b4.button = 1'b1;
                #1 prod[7:4] = b4.out;
                b4.button = 1'b0;
            end
            if (c < 7) @(negedge clk);
        end
    endtask

    task automatic observe8(input int unsigned sv,
                            output int bcnt, output int dat, output int dcnt,
                            output int ovl, output logic [15:0] prod);
        bcnt = 0; dat = -1; dcnt = 0; ovl = 0; prod = '0;
        @(negedge clk);
        b8.s = 4'(sv);
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (b8.busy) bcnt++;
            if (b8.busy && b8.done) ovl++;
            if (b8.done) begin
                dcnt++;
                dat = c;
                b8.button = 1'b0;
                #1 prod[7:0] = b8.out;
                b8.button = 1'b1;
                #1 prod[15:8] = b8.out;
                b8.button = 1'b0;
            end
            if (c < 11) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        b4.s = '0; b4.start = 1'b0; b4.button = 1'b0;
        b8.s = '0; b8.start = 1'b0; b8.button = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b4.out !== 4'h0 || b4.busy !== 1'b0 || b4.done !== 1'b0) begin
            errors++;
            $display("FAIL reset4 out=%h busy=%b done=%b required 0/0/0", b4.out, b4.busy, b4.done);
        end
        checks++;
        if (b8.out !== 8'h00 || b8.busy !== 1'b0 || b8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset8 out=%h busy=%b done=%b required 0/0/0", b8.out, b8.busy, b8.done);
        end
        rst_n = 1'b1;
    endtask

    // Common timing checks for one WIDTH=4 multiply.
    task automatic test_one4(input string name, input int unsigned sv, input int smid);
        int bcnt, dat, dcnt, ovl;
        logic [7:0] prod;
        logic [7:0] exp_p;
        exp_p = 8'(ref_prod(sv, 4, 4));
        observe4(sv, smid, bcnt, dat, dcnt, ovl, prod);
        checks++;
        if (bcnt != 4 || dat != 5 || dcnt != 1 || ovl != 0) begin
            errors++;
            $display("FAIL %s_timing busy_cycles=%0d done_at=%0d done_count=%0d overlap=%0d required 4/5/1/0",
                     name, bcnt, dat, dcnt, ovl);
        end
        checks++;
        if (prod !== exp_p) begin
            errors++;
            $display("FAIL %s_product s=%0d got=%h required=%h", name, sv, prod, exp_p);
        end
        // Result must still be held after returning to IDLE.
        checks++;
        if (b4.out !== exp_p[3:0]) begin
            errors++;
            $display("FAIL %s_hold got=%h required=%h", name, b4.out, exp_p[3:0]);
        end
    endtask

    task automatic test_basic();
        test_one4("s0", 0, -1);
    endtask

    task automatic test_operand_latch();
        test_one4("s6_to_s3", 6, 3);
    endtask

    task automatic test_zero_products();
        test_one4("s7", 7, -1);
        test_one4("s9", 9, -1);
    endtask

    task automatic test_back_to_back();
        int dpos[$];
        int bad_out;
        bad_out = 0;
        @(negedge clk);
        b4.s = 4'd1;
        b4.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (b4.done) begin
                dpos.push_back(c);
                if (b4.out !== 4'hC) bad_out++;
            end
        end
        b4.start = 1'b0;
        checks++;
        if (dpos.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d required=3", dpos.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dpos[k] != 5 + 6 * k) begin
                    errors++;
                    $display("FAIL b2b_spacing pulse%0d at=%0d required=%0d", k, dpos[k], 5 + 6 * k);
                end
            end
        end
        checks++;
        if (bad_out != 0) begin
            errors++;
            $display("FAIL b2b_out wrong_results=%0d required=0", bad_out);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        b4.s = 4'd5;
        b4.button = 1'b0;
        b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        checks++;
        if (b4.busy !== 1'b1 || b4.out !== 4'hC) begin
            errors++;
            $display("FAIL abort_prerun busy=%b out=%h required 1/c", b4.busy, b4.out);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.out !== 4'h0) begin
            errors++;
            $display("FAIL abort_now busy=%b done=%b out=%h required 0/0/0", b4.busy, b4.done, b4.out);
        end
        b4.button = 1'b1;
        #1;
        checks++;
        if (b4.out !== 4'h0) begin
            errors++;
            $display("FAIL abort_high got=%h required=0", b4.out);
        end
        b4.button = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.out !== 4'h0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_idle activity_cycles=%0d required=0", seen);
        end
    endtask

    task automatic test_random4();
        int bcnt, dat, dcnt, ovl;
        logic [7:0] prod;
        logic [7:0] exp_p;
        int unsigned sv;
        for (int i = 0; i < 12; i++) begin
            sv = $urandom_range(15, 0);
            exp_p = 8'(ref_prod(sv, 4, 4));
            observe4(sv, int'($urandom_range(15, 0)), bcnt, dat, dcnt, ovl, prod);
            checks++;
            if (prod !== exp_p || dat != 5 || dcnt != 1) begin
                errors++;
                $display("FAIL rand4 s=%0d got=%h done_at=%0d count=%0d required=%h/5/1",
                         sv, prod, dat, dcnt, exp_p);
            end
        end
    endtask

    task automatic test_wide8();
        int bcnt, dat, dcnt, ovl;
        logic [15:0] prod;
        logic [15:0] exp_p;
        int unsigned list[6];
        list[0] = 3; list[1] = 7;
        for (int i = 2; i < 6; i++) list[i] = $urandom_range(15, 0);
        for (int i = 0; i < 6; i++) begin
            exp_p = 16'(ref_prod(list[i], 8, 4));
            observe8(list[i], bcnt, dat, dcnt, ovl, prod);
            checks++;
            if (bcnt != 8 || dat != 9 || dcnt != 1 || ovl != 0) begin
                errors++;
                $display("FAIL w8_timing s=%0d busy_cycles=%0d done_at=%0d count=%0d overlap=%0d required 8/9/1/0",
                         list[i], bcnt, dat, dcnt, ovl);
            end
            checks++;
            if (prod !== exp_p) begin
                errors++;
                $display("FAIL w8_product s=%0d got=%h required=%h", list[i], prod, exp_p);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_operand_latch();
        test_zero_products();
        test_back_to_back();
        test_reset_abort();
        test_random4();
        test_wide8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq_fpga.md
Name: mul_seq_fpga

Overview:
- Board-level multiplier demo block, parametrised successor of the combinational table-driven multiplier.
- Select lines pick an operand pair from a fixed generated table. A start strobe launches a sequential shift-add multiply.
- Button chooses the low or high half of the latched product for the board LEDs/display.
- Adds start/busy/done handshake, operand latching, a held result register and width generalisation.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH; display output is WIDTH.
- SEL_W, 4, width of select input s; table holds 2^(SEL_W-1) valid entries.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s  input  SEL_W  operand-pair select.
- start  input  1  request multiply; sampled only in IDLE.
- button  input  1  display half select: 0 = product[WIDTH-1:0], 1 = product[2*WIDTH-1:WIDTH].
- out  output  WIDTH  selected half of the result register.
- busy  output  1  high while multiply in progress (RUN state).
- done  output  1  one-cycle pulse when the result register is updated.

Behaviour:
- Operand table (combinational from s):
  - s < 2^(SEL_W-1): a = (2*s+1) mod 2^WIDTH, b = (2*s+2) mod 2^WIDTH.
  - Otherwise a = 0, b = 0.
  - With defaults: s=0 gives 1,2; s=7 gives 15,0; s=8..15 give 0,0.
- Reset (async, rst_n=0): state=IDLE, step counter=0, working regs=0, result register=0, busy=0, done=0; out therefore 0. Release is synchronous to clk.
- FSM states:
  - IDLE: busy=0, done=0. If start=1 at a rising edge, latch a→multiplicand, b→multiplier; working product P[2*WIDTH:0] = {0, b}; counter=0; go to RUN.
  - RUN: busy=1. Each edge performs one step:
    - if P[0]=1, upper part P[2*WIDTH:WIDTH] += multiplicand (WIDTH+1-bit sum, carry kept);
    - then P shifts right by 1; counter increments.
    - On the edge completing step WIDTH, the result register loads P[2*WIDTH-1:0] and the FSM goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. The next edge always goes to IDLE; start is ignored in DONE.
- Latency: start sampled at edge E0. busy is high for the WIDTH cycles between E0 and E_WIDTH. done is high in the cycle after E_WIDTH, and the result is visible on out in that same cycle. Earliest next accepted start is at E_(WIDTH+2).
- s changes after E0 do not affect the running multiply (operands latched). start held high in RUN is ignored. start held continuously high causes back-to-back multiplies every WIDTH+2 cycles.
- The result register holds the last product until the next DONE. out = button ? result[2*WIDTH-1:WIDTH] : result[WIDTH-1:0]. out is combinational from the result register and button, with no register stage; button may change at any time.
- Arithmetic: unsigned; 2*WIDTH-bit product is exact, no overflow possible.
- Reset asserted mid-RUN aborts immediately: result cleared to 0, no done pulse. After release the FSM waits in IDLE for a new start.
- busy and done are never high simultaneously.

Test Plan:
1. Reset, s=0, pulse start 1 cycle → busy high 4 cycles, done pulses once 4 edges after the start edge; button=0 → out=4'h2, button=1 → out=4'h0.
2. s=6, start; change s to 3 during RUN → product 13*14=182=8'hB6; button=0 → out=4'h6, button=1 → out=4'hB; s change has no effect.
3. s=7 (15*0) and s=9 (table default 0*0) → out=0 for both halves; done still pulses after 4 cycles. A prior nonzero result is overwritten to 0.
4. Hold start=1 continuously with s=1 (3*4) → done pulses every 6 cycles, out(low)=4'hC each time; extra start edges during RUN/DONE are ignored.
5. Start s=5 (11*12=132), assert rst_n=0 at RUN step 2 → out=0, busy=0, no done pulse; after release with no start, outputs stay 0.
6. WIDTH=8, SEL_W=4: s=3 gives 7*8 → after 8 RUN cycles out(low)=8'h38, out(high)=8'h00; s=7 gives 15*16=240 → low=8'hF0.
